retirement_rat: RTL and testbench

//  Retirement register alias table: holds the committed arch->phys mapping for all 32 arch regs.

---
 rtl/retirement_rat_pkg.sv | 14 +
 rtl/retirement_rat_if.sv | 25 ++
 rtl/retirement_rat.sv | 59 +++++
 tb/tb_retirement_rat.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/retirement_rat_pkg.sv
// Shared widths, index types and the commit-update predicate for the retirement RAT.
package retirement_rat_pkg;
  localparam int ARCH_REGS      = 32;
  localparam int ARCH_WIDTH     = $clog2(ARCH_REGS);
  localparam int DEF_PHYS_WIDTH = 6;

  typedef logic [DEF_PHYS_WIDTH-1:0] physicalIndexing;
  typedef logic [ARCH_WIDTH-1:0]     archIndexing;

  // x0 is hardwired, so commits targeting it never displace a mapping.
  function automatic logic commit_updates(input logic valid, input logic we, input archIndexing rd);
    return valid && we && (rd != '0);
  endfunction
endpackage

// File: rtl/retirement_rat_if.sv
// Commit-port, free-list and committed-map signals between the ROB/free_list side and the RRAT.
interface retirement_rat_if #(
  parameter int PHYS_WIDTH = retirement_rat_pkg::DEF_PHYS_WIDTH
) ();
  import retirement_rat_pkg::*;

  logic                              commit_valid_in;
  archIndexing                       commit_rd_in;
  logic [PHYS_WIDTH-1:0]             commit_pd_in;
  logic                              commit_regf_we_in;
  logic                              global_branch_signal;
  logic                              free_enqueue_out;
  logic [PHYS_WIDTH-1:0]             free_wdata_out;
  logic [ARCH_REGS*PHYS_WIDTH-1:0]   rrat_map_out;

  modport master (
    output commit_valid_in, commit_rd_in, commit_pd_in, commit_regf_we_in, global_branch_signal,
    input  free_enqueue_out, free_wdata_out, rrat_map_out
  );

  modport slave (
    input  commit_valid_in, commit_rd_in, commit_pd_in, commit_regf_we_in, global_branch_signal,
    output free_enqueue_out, free_wdata_out, rrat_map_out
  );
endinterface

// File: rtl/retirement_rat.sv
// Retirement RAT: committed arch->phys map; each updating commit returns the displaced phys reg
// to the free list one cycle later and the map is exposed with this cycle's commit already applied.
module retirement_rat
  import retirement_rat_pkg::*;
#(
  parameter int PHYS_WIDTH = DEF_PHYS_WIDTH
) (
  input  logic            i_clk,
  input  logic            i_rst,
  retirement_rat_if.slave bus
);

  logic [PHYS_WIDTH-1:0]           r_map [ARCH_REGS];
  logic                            r_free_valid;
  logic [PHYS_WIDTH-1:0]           r_free_data;
  logic                            w_update;
  logic [PHYS_WIDTH-1:0]           w_old_pd;
  logic [ARCH_REGS*PHYS_WIDTH-1:0] w_map_next;
  logic                            w_unused_flush;

  // The committed map is architectural truth, so a flush never alters it.
  assign w_unused_flush = bus.global_branch_signal;

  assign w_update = commit_updates(bus.commit_valid_in, bus.commit_regf_we_in, bus.commit_rd_in);
  assign w_old_pd = r_map[bus.commit_rd_in];

  // Next-state map view so front-end recovery sees a commit landing in the flush cycle.
  always_comb begin
    w_map_next = '0;
    for (int i = 0; i < ARCH_REGS; i++) begin
      w_map_next[i*PHYS_WIDTH +: PHYS_WIDTH] =
        (w_update && (bus.commit_rd_in == archIndexing'(i))) ? bus.commit_pd_in : r_map[i];
    end
  end

  // Map state and the registered free-list return path.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        r_map[i] <= PHYS_WIDTH'(i);
      end
      r_free_valid <= 1'b0;
      r_free_data  <= '0;
    end else begin
      r_free_valid <= w_update;
      if (w_update) begin
        r_map[bus.commit_rd_in] <= bus.commit_pd_in;
        r_free_data             <= w_old_pd;
      end else begin
        r_free_data             <= r_free_data;
      end
    end
  end

  assign bus.free_enqueue_out = r_free_valid;
  assign bus.free_wdata_out   = r_free_data;
  assign bus.rrat_map_out     = w_map_next;

endmodule

// File: tb/tb_retirement_rat.sv
// Randomised and directed checks of retirement_rat against an array/queue reference model.
module tb_retirement_rat;
  import retirement_rat_pkg::*;

  localparam int PW = DEF_PHYS_WIDTH;
  localparam int NR = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  retirement_rat_if #(.PHYS_WIDTH(PW)) bus ();
  retirement_rat #(.PHYS_WIDTH(PW)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference model: committed map, free-list contents, expected registered free output.
  int m_map [NR];
  int free_q [$];
  int exp_enq, exp_wdata;
  logic [NR*PW-1:0] exp_vec;
  int nxt_map [NR];
  int nxt_enq, nxt_wdata;
  bit nxt_rst;

  task automatic reset_free_list();
    free_q.delete();
    for (int k = 32; k < 64; k++) free_q.push_back(k);
  endtask

  task automatic take(input int v);
    int idx [$];
    idx = free_q.find_first_index(x) with (x == v);
    if (idx.size() > 0) free_q.delete(idx[0]);
  endtask

  // Apply inputs and predict both the combinational map and the post-edge state.
  task automatic drive(input bit r, input bit v, input bit we, input bit f, input int rd, input int pd);
    bit upd;
    rst = r;
    bus.commit_valid_in      = v;
    bus.commit_regf_we_in    = we;
    bus.global_branch_signal = f;
    bus.commit_rd_in         = 5'(rd);
    bus.commit_pd_in         = PW'(pd);
    upd = v && we && (rd != 0);
    for (int a = 0; a < NR; a++) begin
      exp_vec[a*PW +: PW] = PW'((upd && rd == a) ? pd : m_map[a]);
      nxt_map[a] = m_map[a];
    end
    nxt_rst   = r;
    nxt_wdata = exp_wdata;
    nxt_enq   = 0;
    if (r) begin
      for (int a = 0; a < NR; a++) nxt_map[a] = a;
      nxt_wdata = 0;
    end else if (upd) begin
      nxt_enq     = 1;
      nxt_wdata   = m_map[rd];
      nxt_map[rd] = pd;
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  // Advance one clock; the free list absorbs whatever the DUT actually returned.
  task automatic tick();
    @(posedge clk);
    for (int a = 0; a < NR; a++) m_map[a] = nxt_map[a];
    exp_enq   = nxt_enq;
    exp_wdata = nxt_wdata;
    if (nxt_rst) reset_free_list();
    #1;
    if (!nxt_rst && bus.free_enqueue_out === 1'b1) free_q.push_back(int'(bus.free_wdata_out));
  endtask

  function automatic int conservation_bad();
    int cnt [64];
    int bad = 0;
    foreach (cnt[k]) cnt[k] = 0;
    for (int a = 0; a < NR; a++) cnt[int'(bus.rrat_map_out[a*PW +: PW])]++;
    foreach (free_q[k]) if (free_q[k] >= 0 && free_q[k] < 64) cnt[free_q[k]]++;
    foreach (cnt[k]) if (cnt[k] != 1) bad++;
    bad += (free_q.size() != 32) ? 1 : 0;
    return bad;
  endfunction

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    tick();
    idle();
  endtask

  task automatic test_reset();
    logic [NR*PW-1:0] ident;
    do_reset();
    @(negedge clk);
    for (int a = 0; a < NR; a++) ident[a*PW +: PW] = PW'(a);
    checks++;
    if (bus.rrat_map_out !== ident) begin
      errors++; $display("FAIL reset_map got %h want %h", bus.rrat_map_out, ident);
    end
    checks++;
    if (bus.free_enqueue_out !== 1'b0 || bus.free_wdata_out !== PW'(0)) begin
      errors++; $display("FAIL reset_free got en=%b data=%0d want en=0 data=0", bus.free_enqueue_out, bus.free_wdata_out);
    end
    checks++;
    if (conservation_bad() !== 0) begin
      errors++; $display("FAIL reset_conservation got %0d bad values want 0", conservation_bad());
    end
  endtask

  task automatic test_single_commit();
    do_reset();
    take(40);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 5, 40);
    @(negedge clk);
    checks++;
    if (bus.rrat_map_out[5*PW +: PW] !== PW'(40)) begin
      errors++; $display("FAIL single_map_comb got %0d want 40", bus.rrat_map_out[5*PW +: PW]);
    end
    tick();
    checks++;
    if (bus.free_enqueue_out !== 1'b1 || bus.free_wdata_out !== PW'(5)) begin
      errors++; $display("FAIL single_free got en=%b data=%0d want en=1 data=5", bus.free_enqueue_out, bus.free_wdata_out);
    end
    idle();
    tick();
    checks++;
    if (bus.free_enqueue_out !== 1'b0 || bus.free_wdata_out !== PW'(5)) begin
      errors++; $display("FAIL single_hold got en=%b data=%0d want en=0 data=5", bus.free_enqueue_out, bus.free_wdata_out);
    end
    checks++;
    if (bus.rrat_map_out[5*PW +: PW] !== PW'(40) || conservation_bad() !== 0) begin
      errors++; $display("FAIL single_map got %0d want 40 (conservation bad %0d)", bus.rrat_map_out[5*PW +: PW], conservation_bad());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    take(40);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 5, 40);
    tick();
    checks++;
    if (bus.free_enqueue_out !== 1'b1 || bus.free_wdata_out !== PW'(5)) begin
      errors++; $display("FAIL b2b_first got en=%b data=%0d want en=1 data=5", bus.free_enqueue_out, bus.free_wdata_out);
    end
    take(41);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 5, 41);
    tick();
    checks++;
    if (bus.free_enqueue_out !== 1'b1 || bus.free_wdata_out !== PW'(40)) begin
      errors++; $display("FAIL b2b_second got en=%b data=%0d want en=1 data=40", bus.free_enqueue_out, bus.free_wdata_out);
    end
    idle();
    tick();
    checks++;
    if (bus.rrat_map_out[5*PW +: PW] !== PW'(41) || conservation_bad() !== 0) begin
      errors++; $display("FAIL b2b_map got %0d want 41 (conservation bad %0d)", bus.rrat_map_out[5*PW +: PW], conservation_bad());
    end
  endtask

  task automatic test_no_update();
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 0, 33);
    @(negedge clk);
    checks++;
    if (bus.rrat_map_out[0 +: PW] !== PW'(0)) begin
      errors++; $display("FAIL rd0_map got %0d want 0", bus.rrat_map_out[0 +: PW]);
    end
    tick();
    checks++;
    if (bus.free_enqueue_out !== 1'b0) begin
      errors++; $display("FAIL rd0_free got en=%b want 0", bus.free_enqueue_out);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 7, 34);
    tick();
    checks++;
    if (bus.free_enqueue_out !== 1'b0) begin
      errors++; $display("FAIL we0_free got en=%b want 0", bus.free_enqueue_out);
    end
    idle();
    @(negedge clk);
    checks++;
    if (bus.rrat_map_out[7*PW +: PW] !== PW'(7) || bus.rrat_map_out[0 +: PW] !== PW'(0) || conservation_bad() !== 0) begin
      errors++; $display("FAIL no_update_map got r7=%0d r0=%0d want 7 0", bus.rrat_map_out[7*PW +: PW], bus.rrat_map_out[0 +: PW]);
    end
  endtask

  task automatic test_flush();
    do_reset();
    take(51);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4, 51);
    tick();
    take(50);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 3, 50);
    @(negedge clk);
    checks++;
    if (bus.rrat_map_out[3*PW +: PW] !== PW'(50) || bus.free_enqueue_out !== 1'b1 || bus.free_wdata_out !== PW'(4)) begin
      errors++; $display("FAIL flush_cycle got map3=%0d en=%b data=%0d want 50 1 4",
                         bus.rrat_map_out[3*PW +: PW], bus.free_enqueue_out, bus.free_wdata_out);
    end
    tick();
    checks++;
    if (bus.free_enqueue_out !== 1'b1 || bus.free_wdata_out !== PW'(3)) begin
      errors++; $display("FAIL flush_after got en=%b data=%0d want en=1 data=3", bus.free_enqueue_out, bus.free_wdata_out);
    end
    idle();
    tick();
    checks++;
    if (bus.rrat_map_out[3*PW +: PW] !== PW'(50) || conservation_bad() !== 0) begin
      errors++; $display("FAIL flush_map got %0d want 50 (conservation bad %0d)", bus.rrat_map_out[3*PW +: PW], conservation_bad());
    end
  endtask

  task automatic test_reset_wins();
    do_reset();
    take(44);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8, 44);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 9, 45);
    tick();
    checks++;
    if (bus.free_enqueue_out !== 1'b0 || bus.free_wdata_out !== PW'(0)) begin
      errors++; $display("FAIL reset_wins_free got en=%b data=%0d want en=0 data=0", bus.free_enqueue_out, bus.free_wdata_out);
    end
    idle();
    @(negedge clk);
    checks++;
    if (bus.rrat_map_out[9*PW +: PW] !== PW'(9) || bus.rrat_map_out[8*PW +: PW] !== PW'(8) || conservation_bad() !== 0) begin
      errors++; $display("FAIL reset_wins_map got r9=%0d r8=%0d want 9 8", bus.rrat_map_out[9*PW +: PW], bus.rrat_map_out[8*PW +: PW]);
    end
  endtask

  task automatic test_random();
    int n_bad = 0;
    do_reset();
    for (int it = 0; it < 500; it++) begin
      bit r, v, we, f;
      int rd, pd;
      r  = ($urandom_range(0, 59) == 0);
      v  = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 4) != 0);
      f  = ($urandom_range(0, 9) == 0);
      rd = $urandom_range(0, NR-1);
      pd = $urandom_range(0, 63);
      if (v && we && rd != 0 && !r) begin
        if (free_q.size() > 0) pd = free_q.pop_front();
        else we = 1'b0;
      end
      drive(r, v, we, f, rd, pd);
      @(negedge clk);
      checks++;
      if (bus.rrat_map_out !== exp_vec) begin
        errors++; n_bad++;
        if (n_bad < 5) $display("FAIL rand_map it=%0d got %h want %h", it, bus.rrat_map_out, exp_vec);
      end
      tick();
      checks++;
      if (bus.free_enqueue_out !== 1'(exp_enq) || bus.free_wdata_out !== PW'(exp_wdata)) begin
        errors++; n_bad++;
        if (n_bad < 5) $display("FAIL rand_free it=%0d got en=%b data=%0d want en=%0d data=%0d",
                                it, bus.free_enqueue_out, bus.free_wdata_out, exp_enq, exp_wdata);
      end
    end
    idle();
    tick();
    checks++;
    if (conservation_bad() !== 0) begin
      errors++; $display("FAIL rand_conservation got %0d bad values want 0", conservation_bad());
    end
  endtask

  initial begin
    for (int a = 0; a < NR; a++) m_map[a] = a;
    exp_enq = 0;
    exp_wdata = 0;
    reset_free_list();
    test_reset();
    test_single_commit();
    test_back_to_back();
    test_no_update();
    test_flush();
    test_reset_wins();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
